// File: rtl/bus_resp_pkg.sv
// Shared definitions for bus_mem_responder: FSM states, error word and the
// legal wait-state range.
package bus_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } bus_resp_state_t;

  localparam logic [31:0] BUS_RESP_ERR_WORD    = 32'hDEAD_BEEF;
  localparam int          BUS_RESP_LATENCY_MIN = 0;
  localparam int          BUS_RESP_LATENCY_MAX = 15;

endpackage

// File: rtl/bus_resp_ram.sv
// Single-port byte-lane RAM with a registered read port; the array itself is
// never reset, and the read register only moves on a read access.
module bus_resp_ram
  import bus_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  wr_en,
  input  logic [3:0]            byte_en,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wr_data,
  output logic [31:0]           rd_data
);

  logic [31:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (en) begin
      if (wr_en) begin
        for (int n = 0; n < 4; n++) begin
          if (byte_en[n]) begin
            mem[addr][8*n +: 8] <= wr_data[8*n +: 8];
          end
        end
      end else begin
        rd_data <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/bus_mem_responder.sv
// Bus target with programmable wait states in front of a byte-lane RAM.
// Define BUS_RESP_RANGE_CHECK_EN to add address range checking and o_err.
module bus_mem_responder
  import bus_resp_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LATENCY    = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_bus_en,
  input  logic        i_wr_en,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wr_data,
  input  logic [3:0]  i_byte_en,
  output logic        o_ack,
  output logic [31:0] o_rd_data
`ifdef BUS_RESP_RANGE_CHECK_EN
  ,
  output logic        o_err
`endif
);

  if (LATENCY < BUS_RESP_LATENCY_MIN || LATENCY > BUS_RESP_LATENCY_MAX) begin : g_bad_latency
    $error("bus_mem_responder: LATENCY %0d outside legal range", LATENCY);
  end

  localparam logic [3:0] LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  bus_resp_state_t state, state_next;
  logic [3:0]      cnt, cnt_next;
  logic            capture, access;

  logic                  cap_wr_en, cap_in_range;
  logic [DEPTH_LOG2-1:0] cap_index;
  logic [31:0]           cap_wr_data;
  logic [3:0]            cap_byte_en;

  logic [31:0]           req_offset;
  logic [DEPTH_LOG2-1:0] req_index;
  logic                  req_in_range;
  logic                  unused_offset_bits;

  logic                  live, acc_wr_en, acc_in_range, ram_en;
  logic [DEPTH_LOG2-1:0] acc_index;
  logic [31:0]           acc_wr_data, ram_rd_data;
  logic [3:0]            acc_byte_en;
  logic                  rd_valid;

  assign req_offset = i_addr - BASE_ADDR;
  assign req_index  = req_offset[DEPTH_LOG2+1:2];
`ifdef BUS_RESP_RANGE_CHECK_EN
  assign req_in_range = (req_offset[31:DEPTH_LOG2+2] == '0);
`else
  assign req_in_range = 1'b1;
`endif
  assign unused_offset_bits = ^{req_offset[1:0], req_offset[31:DEPTH_LOG2+2]};

  // With zero wait states the access happens on the accept edge, so IDLE
  // steers the live request into the RAM; otherwise the captured copy is used.
  assign live         = (state == IDLE);
  assign acc_wr_en    = live ? i_wr_en      : cap_wr_en;
  assign acc_in_range = live ? req_in_range : cap_in_range;
  assign acc_index    = live ? req_index    : cap_index;
  assign acc_wr_data  = live ? i_wr_data    : cap_wr_data;
  assign acc_byte_en  = live ? i_byte_en    : cap_byte_en;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    access     = 1'b0;
    case (state)
      IDLE: begin
        if (i_bus_en) begin
          capture = 1'b1;
          if (LATENCY == 0) begin
            state_next = DONE;
            access     = 1'b1;
          end else begin
            state_next = BUSY;
            cnt_next   = LAT_LOAD;
          end
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          state_next = DONE;
          access     = 1'b1;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      DONE: begin
        if (!i_bus_en) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The RAM has no reset, so keep it from writing while reset is held.
  assign ram_en = access && acc_in_range && i_rst;

  bus_resp_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk    (i_clk),
    .en     (ram_en),
    .wr_en  (acc_wr_en),
    .byte_en(acc_byte_en),
    .addr   (acc_index),
    .wr_data(acc_wr_data),
    .rd_data(ram_rd_data)
  );

`ifdef BUS_RESP_RANGE_CHECK_EN
  logic err_q;
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      cap_wr_en    <= 1'b0;
      cap_in_range <= 1'b0;
      cap_index    <= '0;
      cap_wr_data  <= '0;
      cap_byte_en  <= '0;
      rd_valid     <= 1'b0;
`ifdef BUS_RESP_RANGE_CHECK_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (capture) begin
        cap_wr_en    <= i_wr_en;
        cap_in_range <= req_in_range;
        cap_index    <= req_index;
        cap_wr_data  <= i_wr_data;
        cap_byte_en  <= i_byte_en;
      end
      if (access) begin
        rd_valid <= !acc_wr_en && acc_in_range;
`ifdef BUS_RESP_RANGE_CHECK_EN
        err_q    <= !acc_in_range;
      end else if (state == DONE && !i_bus_en) begin
        err_q    <= 1'b0;
`endif
      end
    end
  end

  assign o_ack = (state == DONE);

`ifdef BUS_RESP_RANGE_CHECK_EN
  assign o_err     = err_q;
  assign o_rd_data = err_q ? BUS_RESP_ERR_WORD : (rd_valid ? ram_rd_data : 32'h0);
`else
  assign o_rd_data = rd_valid ? ram_rd_data : 32'h0;
`endif

endmodule
